// File: rtl/bus_map_pkg.sv
// Address map, slave indices and FSM encoding shared by the CPU data-side bridge.
package bus_map_pkg;

  localparam int NSLV_MAP = 4;

  localparam int SLV_DM   = 0;
  localparam int SLV_TMR0 = 1;
  localparam int SLV_TMR1 = 2;
  localparam int SLV_UART = 3;

  localparam logic [31:0] DM_BASE    = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT   = 32'h0000_2FFF;
  localparam logic [31:0] TMR0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TMR0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] TMR1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TMR1_LIMIT = 32'h0000_7F1B;
  localparam logic [31:0] UART_BASE  = 32'h0000_7F30;
  localparam logic [31:0] UART_LIMIT = 32'h0000_7F3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Offset form keeps a zero base from producing an always-true compare.
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] base,
                                    input logic [31:0] limit);
    return (a - base) <= (limit - base);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder: one-hot slave select plus an unmapped/misaligned fault flag.
module addr_decode
  import bus_map_pkg::*;
(
  input  logic [31:0]         addr,
  input  logic                we,
  input  logic [3:0]          byteen,
  output logic [NSLV_MAP-1:0] sel,
  output logic                fault
);

  logic [NSLV_MAP-1:0] hit;
  logic                periph;
  logic                misaligned;

  always_comb begin
    hit           = '0;
    hit[SLV_DM]   = in_range(addr, DM_BASE, DM_LIMIT);
    hit[SLV_TMR0] = in_range(addr, TMR0_BASE, TMR0_LIMIT);
    hit[SLV_TMR1] = in_range(addr, TMR1_BASE, TMR1_LIMIT);
    hit[SLV_UART] = in_range(addr, UART_BASE, UART_LIMIT);
    periph        = hit[SLV_TMR0] | hit[SLV_TMR1] | hit[SLV_UART];
    // Peripherals are word-only; dm writes may be sub-word through byteen.
    misaligned    = (periph && ((addr[1:0] != 2'b00) || (we && (byteen != 4'hF)))) ||
                    (hit[SLV_DM] && !we && (addr[1:0] != 2'b00));
    fault         = (hit == '0) || misaligned;
    sel           = fault ? '0 : hit;
  end

endmodule

// File: rtl/bus_demux_bridge.sv
// CPU data-side bridge: decodes one request to dm/timer0/timer1/uart, waits for ack or timeout.
module bus_demux_bridge
  import bus_map_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int NSLV    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_byteen,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  output logic [3:0]           slv_byteen,
  input  logic [32*NSLV-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ack
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t         state, state_n;
  logic [7:0]     cnt, cnt_n;
  logic [NSLV-1:0] sel_n;
  logic           ready_n, err_n, capture;
  logic [31:0]    rdata_n, ack_data;
  logic [NSLV-1:0] dec_sel;
  logic           dec_fault;

  addr_decode u_addr_decode (
    .addr   (cpu_addr),
    .we     (cpu_we),
    .byteen (cpu_byteen),
    .sel    (dec_sel),
    .fault  (dec_fault)
  );

  always_comb begin
    ack_data = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_sel[i]) ack_data = ack_data | slv_rdata[32*i +: 32];
    end
  end

  // Response outputs are computed one state ahead so they come straight from flops.
  always_comb begin
    state_n = state;
    sel_n   = slv_sel;
    cnt_n   = cnt;
    ready_n = 1'b0;
    err_n   = 1'b0;
    rdata_n = '0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          capture = 1'b1;
          if (dec_fault) begin
            sel_n   = '0;
            state_n = RESP;
            ready_n = 1'b1;
            err_n   = 1'b1;
          end else begin
            sel_n   = dec_sel;
            cnt_n   = '0;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if ((slv_ack & slv_sel) != '0) begin
          sel_n   = '0;
          state_n = RESP;
          ready_n = 1'b1;
          rdata_n = slv_we ? 32'h0 : ack_data;
        end else if (cnt == CNT_LAST) begin
          sel_n   = '0;
          state_n = RESP;
          ready_n = 1'b1;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      slv_sel    <= '0;
      cpu_ready  <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      slv_we     <= 1'b0;
      slv_addr   <= '0;
      slv_wdata  <= '0;
      slv_byteen <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      slv_sel   <= sel_n;
      cpu_ready <= ready_n;
      cpu_err   <= err_n;
      cpu_rdata <= rdata_n;
      if (capture) begin
        slv_we     <= cpu_we;
        slv_addr   <= cpu_addr;
        slv_wdata  <= cpu_wdata;
        slv_byteen <= cpu_we ? cpu_byteen : 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_bus_demux_bridge.sv
// Self-checking bench for bus_demux_bridge: directed scenarios plus random back-to-back traffic.
module tb_bus_demux_bridge;

  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_byteen = '0;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [3:0]   slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_byteen;
  logic [127:0] slv_rdata = '0;
  logic [3:0]   slv_ack = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];  // {err, rdata}

  bus_demux_bridge #(.TIMEOUT(TO), .NSLV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .slv_sel    (slv_sel),
    .slv_we     (slv_we),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_byteen (slv_byteen),
    .slv_rdata  (slv_rdata),
    .slv_ack    (slv_ack)
  );

  always #5 clk = ~clk;

  // Cycle numbering: the cycle in which the request is first sampled is cycle 1.
  task automatic do_txn(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic [3:0]  ack_mask,
    input  int          ack_wait,
    input  int          slot,
    input  logic [31:0] data,
    output int          rdy_cyc,
    output int          sel_cyc,
    output logic [3:0]  sel_or,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] cap_wdata,
    output logic [3:0]  cap_be,
    output logic [31:0] cap_addr
  );
    logic [127:0] rd;
    int wait_n;
    for (int i = 0; i < 4; i++) rd[32*i +: 32] = $urandom;
    rd[32*slot +: 32] = data;
    rdy_cyc = -1; sel_cyc = 0; sel_or = '0; err = 1'b0; rdata = '0;
    cap_wdata = '0; cap_be = '0; cap_addr = '0; wait_n = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_byteen = be;
    slv_rdata = rd; slv_ack = '0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) begin
        cap_wdata = slv_wdata; cap_be = slv_byteen; cap_addr = slv_addr;
      end
      if (slv_sel != '0) begin
        sel_cyc++; sel_or = sel_or | slv_sel; wait_n++;
      end
      if (cpu_ready) begin
        rdy_cyc = k; err = cpu_err; rdata = cpu_rdata;
        break;
      end
      slv_ack = (slv_sel != '0 && wait_n == ack_wait) ? ack_mask : 4'h0;
    end
    cpu_req = 1'b0; slv_ack = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_ready, cpu_err, cpu_rdata} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_cpu_out: got ready=%b err=%b rdata=%h required all 0", cpu_ready, cpu_err, cpu_rdata);
    end
    vectors++;
    if ({slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen} !== 73'h0) begin
      miscompares++;
      $display("FAIL reset_slv_out: got sel=%b we=%b addr=%h wdata=%h be=%h required all 0",
               slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen);
    end
    reset = 1'b0;
  endtask

  task automatic test_dm_read();
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    do_txn(1'b0, 32'h0000_0010, 32'h1234_5678, 4'hF, 4'b0001, 1, 0, 32'hDEAD_BEEF,
           rc, sc, so, e, rd, cw, cb, ca);
    exp = exp_q.pop_front();
    vectors++;
    if ({e, rd} !== exp) begin miscompares++; $display("FAIL dm_read_resp: got %h required %h", {e, rd}, exp); end
    vectors++;
    if (rc !== 3) begin miscompares++; $display("FAIL dm_read_latency: got %0d required 3", rc); end
    vectors++;
    if (so !== 4'b0001 || sc !== 1) begin
      miscompares++; $display("FAIL dm_read_sel: got %b for %0d cycles required 0001 for 1", so, sc);
    end
    vectors++;
    if (cb !== 4'h0 || ca !== 32'h10) begin
      miscompares++; $display("FAIL dm_read_capture: got be=%h addr=%h required be=0 addr=10", cb, ca);
    end
  endtask

  task automatic test_timer1_write();
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h0});
    do_txn(1'b1, 32'h0000_7F14, 32'h0000_0005, 4'hF, 4'b0100, 4, 2, 32'hCAFE_F00D,
           rc, sc, so, e, rd, cw, cb, ca);
    exp = exp_q.pop_front();
    vectors++;
    if ({e, rd} !== exp) begin miscompares++; $display("FAIL tmr1_write_resp: got %h required %h", {e, rd}, exp); end
    vectors++;
    if (so !== 4'b0100 || sc !== 4) begin
      miscompares++; $display("FAIL tmr1_write_sel: got %b for %0d cycles required 0100 for 4", so, sc);
    end
    vectors++;
    if (cw !== 32'h5 || cb !== 4'hF) begin
      miscompares++; $display("FAIL tmr1_write_capture: got wdata=%h be=%h required 5/F", cw, cb);
    end
    vectors++;
    if (rc !== 6) begin miscompares++; $display("FAIL tmr1_write_latency: got %0d required 6", rc); end
  endtask

  task automatic test_errors();
    logic [31:0] a_tbl [6] = '{32'h0000_5000, 32'h0000_7F32, 32'h0000_7F30,
                               32'h0000_3000, 32'h0000_0012, 32'h0000_7F0C};
    logic        w_tbl [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  b_tbl [6] = '{4'hF, 4'hF, 4'b0011, 4'hF, 4'hF, 4'hF};
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b1, 32'h0});
      do_txn(w_tbl[i], a_tbl[i], 32'hFFFF_FFFF, b_tbl[i], 4'hF, 1, 0, 32'h5555_AAAA,
             rc, sc, so, e, rd, cw, cb, ca);
      exp = exp_q.pop_front();
      vectors++;
      if ({e, rd} !== exp || rc !== 2 || so !== 4'h0) begin
        miscompares++;
        $display("FAIL err_case%0d addr=%h: got resp=%h lat=%0d sel=%b required %h/2/0000",
                 i, a_tbl[i], {e, rd}, rc, so, exp);
      end
    end
  endtask

  task automatic test_good_boundaries();
    logic [31:0] a_tbl [3] = '{32'h0000_2FFC, 32'h0000_0013, 32'h0000_7F3C};
    logic        w_tbl [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]  b_tbl [3] = '{4'hF, 4'b1000, 4'h0};
    int          s_tbl [3] = '{0, 0, 3};
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      exp_q.push_back({1'b0, w_tbl[i] ? 32'h0 : d});
      do_txn(w_tbl[i], a_tbl[i], 32'h0, b_tbl[i], 4'(1 << s_tbl[i]), 2, s_tbl[i], d,
             rc, sc, so, e, rd, cw, cb, ca);
      exp = exp_q.pop_front();
      vectors++;
      if ({e, rd} !== exp || rc !== 4 || so !== 4'(1 << s_tbl[i])) begin
        miscompares++;
        $display("FAIL edge_ok%0d addr=%h: got resp=%h lat=%0d sel=%b required %h/4/%b",
                 i, a_tbl[i], {e, rd}, rc, so, exp, 4'(1 << s_tbl[i]));
      end
    end
  endtask

  task automatic test_uart_timeout();
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    exp_q.push_back({1'b1, 32'h0});
    do_txn(1'b0, 32'h0000_7F30, 32'h0, 4'hF, 4'b1000, 0, 3, 32'h1111_2222,
           rc, sc, so, e, rd, cw, cb, ca);
    exp = exp_q.pop_front();
    vectors++;
    if ({e, rd} !== exp) begin miscompares++; $display("FAIL uart_timeout_resp: got %h required %h", {e, rd}, exp); end
    vectors++;
    if (rc !== TO + 2) begin miscompares++; $display("FAIL uart_timeout_latency: got %0d required %0d", rc, TO + 2); end
    vectors++;
    if (so !== 4'b1000 || sc !== TO) begin
      miscompares++; $display("FAIL uart_timeout_sel: got %b for %0d cycles required 1000 for %0d", so, sc, TO);
    end
  endtask

  task automatic test_ack_boundary();
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    exp_q.push_back({1'b0, 32'hA5A5_0F0F});
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 4'b0001, TO, 0, 32'hA5A5_0F0F,
           rc, sc, so, e, rd, cw, cb, ca);
    exp = exp_q.pop_front();
    vectors++;
    if ({e, rd} !== exp || rc !== TO + 2) begin
      miscompares++; $display("FAIL ack_last_cycle: got resp=%h lat=%0d required %h/%0d", {e, rd}, rc, exp, TO + 2);
    end
    exp_q.push_back({1'b1, 32'h0});
    do_txn(1'b0, 32'h0000_0104, 32'h0, 4'hF, 4'b0010, 3, 0, 32'h7777_8888,
           rc, sc, so, e, rd, cw, cb, ca);
    exp = exp_q.pop_front();
    vectors++;
    if ({e, rd} !== exp || rc !== TO + 2) begin
      miscompares++; $display("FAIL ack_unselected: got resp=%h lat=%0d required %h/%0d", {e, rd}, rc, exp, TO + 2);
    end
  endtask

  task automatic test_reset_mid();
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    logic saw_ready;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_byteen = 4'hF; slv_ack = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (slv_sel !== 4'b0001) begin miscompares++; $display("FAIL rst_mid_pre_sel: got %b required 0001", slv_sel); end
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen} !== 107'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got ready=%b sel=%b addr=%h required all 0", cpu_ready, slv_sel, slv_addr);
    end
    reset = 1'b0;
    saw_ready = 1'b0;
    repeat (TO + 4) begin
      @(negedge clk);
      if (cpu_ready) saw_ready = 1'b1;
    end
    vectors++;
    if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_ready: got ready pulse required none"); end
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    do_txn(1'b0, 32'h0000_0024, 32'h0, 4'hF, 4'b0001, 1, 0, 32'h0BAD_F00D,
           rc, sc, so, e, rd, cw, cb, ca);
    exp = exp_q.pop_front();
    vectors++;
    if ({e, rd} !== exp || rc !== 3) begin
      miscompares++; $display("FAIL rst_mid_fresh_read: got resp=%h lat=%0d required %h/3", {e, rd}, rc, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base_tbl [4] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F30};
    int rc, sc; logic [3:0] so; logic e; logic [31:0] rd, cw, ca; logic [3:0] cb; logic [32:0] exp;
    int slot, aw; logic we; logic [31:0] a, d;
    for (int n = 0; n < 10; n++) begin
      slot = $urandom_range(0, 3);
      aw   = $urandom_range(1, 6);
      we   = 1'($urandom_range(0, 1));
      a    = base_tbl[slot] + 32'(4 * $urandom_range(0, 2));
      d    = $urandom;
      exp_q.push_back({1'b0, we ? 32'h0 : d});
      do_txn(we, a, $urandom, 4'hF, 4'(1 << slot), aw, slot, d, rc, sc, so, e, rd, cw, cb, ca);
      exp = exp_q.pop_front();
      vectors++;
      if ({e, rd} !== exp || rc !== aw + 2 || so !== 4'(1 << slot) || sc !== aw) begin
        miscompares++;
        $display("FAIL b2b%0d addr=%h we=%b: got resp=%h lat=%0d sel=%b/%0d required %h/%0d/%b/%0d",
                 n, a, we, {e, rd}, rc, so, sc, exp, aw + 2, 4'(1 << slot), aw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dm_read();
    test_timer1_write();
    test_errors();
    test_good_boundaries();
    test_uart_timeout();
    test_ack_boundary();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_demux_bridge.md
Name: bus_demux_bridge

Overview:
- Takes one CPU data-side request and steers it to exactly one of four slaves: data memory, timer0, timer1, uart.
- Slaves are picked by a fixed address map. Each access waits for the chosen slave's ack, then returns read data or an error to the CPU.
- This is the write/decode direction of the bus. The read-data return path is a registered select of the per-slave data.
- Sits between the CPU memory stage and the peripherals.

Parameters:
- TIMEOUT, 15: max cycles in WAIT before an error response; legal range 1..255.
- NSLV, 4: slave count. Fixed by the address map; not to be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request valid; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_byteen  in  4  byte enables (writes only)
- cpu_ready  out  1  one-cycle response pulse
- cpu_rdata  out  32  read data, valid when cpu_ready and cpu_we was 0
- cpu_err  out  1  valid with cpu_ready; unmapped address, misaligned access or timeout
- slv_sel  out  4  one-hot slave select; bit0 dm, bit1 timer0, bit2 timer1, bit3 uart
- slv_we  out  1  registered copy of cpu_we
- slv_addr  out  32  registered copy of cpu_addr
- slv_wdata  out  32  registered copy of cpu_wdata
- slv_byteen  out  4  registered byteen, forced to 0 on reads
- slv_rdata  in  128  per-slave read data; slave i occupies bits [32i+31:32i]
- slv_ack  in  4  per-slave completion pulse

Behaviour:
- Reset (sync, high): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops it silently, with no cpu_ready.
- Address map: dm 0x0000_0000-0x0000_2FFF; timer0 0x0000_7F00-0x0000_7F0B; timer1 0x0000_7F10-0x0000_7F1B; uart 0x0000_7F30-0x0000_7F3F. Anything else is unmapped.
- Access rules:
  - Misaligned means cpu_addr[1:0] != 0 on any peripheral access, or on a dm read.
  - dm writes may be sub-word, governed by byteen.
  - Peripheral writes require byteen=4'b1111; otherwise the access is misaligned.
- FSM IDLE:
  - No action when cpu_req=0.
  - On cpu_req=1, capture we/addr/wdata/byteen into the slv_* registers.
  - If the address is mapped and aligned: set slv_sel one-hot, clear the counter, go to WAIT.
  - Otherwise: slv_sel=0, go to RESP with err=1.
- FSM WAIT:
  - slv_sel and slv_* are held stable.
  - If slv_ack[k]=1 for the selected k: latch slv_rdata slice k into the rdata register, clear slv_sel, go to RESP with err=0.
  - Acks on unselected bits are ignored.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and there is still no ack: clear slv_sel, go to RESP with err=1 and rdata=0.
  - An ack in the same cycle as the timeout wins: no error.
- FSM RESP:
  - cpu_ready=1 for exactly this cycle; cpu_err and cpu_rdata are driven from registers; go to IDLE.
  - cpu_rdata=0 for writes and for errors.
- Latency from cpu_req accepted in IDLE to cpu_ready:
  - a slave acking in its first WAIT cycle gives 3 cycles;
  - an error gives 2 cycles;
  - a timeout gives TIMEOUT+2 cycles.
- No pipelining: one outstanding request. cpu_req seen during WAIT/RESP is ignored until IDLE. The CPU must hold or re-present it, so back-to-back requests complete every 3 cycles at best.
- All outputs are registered. There is no combinational path from cpu_* or slv_* inputs to any output.

Decomposition:
- Package bus_map_pkg:
  - base/limit constants for the four regions;
  - slave index constants SLV_DM=0, SLV_TMR0=1, SLV_TMR1=2, SLV_UART=3;
  - FSM state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- Sub-module addr_decode: purely combinational. Takes addr, we and byteen; produces sel[3:0] and a fault flag (unmapped or misaligned). It is instantiated once and unit-tested standalone.
- The top holds the FSM, capture registers, counter and the rdata select register.

Test Plan:
- dm read, addr 0x0000_0010; slave0 acks on 1st WAIT cycle with rdata 0xDEAD_BEEF → slv_sel=4'b0001 for 1 cycle; cpu_ready 3 cycles after request; cpu_rdata=0xDEAD_BEEF; cpu_err=0.
- timer1 write, addr 0x0000_7F14, wdata 0x0000_0005, byteen 4'hF; ack after 4 cycles → slv_sel=4'b0100 held for 4 cycles; slv_wdata=5; cpu_ready with err=0 and rdata=0.
- Error cases, each giving cpu_ready 2 cycles after request, err=1, slv_sel never nonzero:
  - read of addr 0x0000_5000 (unmapped);
  - uart write at 0x0000_7F32 (misaligned);
  - uart write with byteen 4'b0011 (partial byteen).
- uart read, no ack, TIMEOUT=15 → slv_sel=4'b1000 for 15 cycles, then cleared; cpu_ready at cycle 17 with err=1 and rdata=0.
- Ack on both edges of the timeout boundary:
  - ack arriving exactly on the 15th WAIT cycle → err=0, data returned;
  - ack on unselected bit slv_ack=4'b0010 while dm is selected → ignored, timeout error results.
- reset asserted during WAIT, then released → all outputs 0 the next cycle; no cpu_ready pulse; a fresh dm read afterwards completes normally in 3 cycles.
